// File: rtl/counter_run_controller.sv
// Front-panel sequencer for the 4-bit counter: debounced buttons, run/pause/load FSM,
// count and display-scan strobes, and a saturating tally of counter wrap-arounds.
module counter_run_controller #(
    parameter int TICK_DIV   = 50000,
    parameter int SCAN_DIV   = 500,
    parameter int DEB_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_load,
    input  logic       btn_dir,
    input  logic       btn_mode,
    input  logic [3:0] data_sw,
    input  logic       cout,
    output logic       enable,
    output logic       load,
    output logic       dir_sel,
    output logic [1:0] mod_sel,
    output logic [3:0] data,
    output logic       count_tick,
    output logic       scan_tick,
    output logic [1:0] state,
    output logic [7:0] wrap_count
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    logic [4:0] btn_raw;
    logic [4:0] press;
    assign btn_raw = {btn_mode, btn_dir, btn_load, btn_stop, btn_start};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_btn
            logic          sync1_reg, sync2_reg;
            logic          deb_reg, deb_d1_reg, deb_d2_reg;
            logic          press_reg;
            logic [DW-1:0] cnt_reg;

            // Edge detect runs one stage behind the debounced level so that the
            // press pulse lands exactly DEB_CYCLES+3 clocks after the first sample.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    deb_reg    <= 1'b0;
                    deb_d1_reg <= 1'b0;
                    deb_d2_reg <= 1'b0;
                    press_reg  <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DW'(DEB_CYCLES - 1)) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DW'(1);
                    end
                    deb_d1_reg <= deb_reg;
                    deb_d2_reg <= deb_d1_reg;
                    press_reg  <= deb_d1_reg & ~deb_d2_reg;
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    logic p_start, p_stop, p_load, p_dir, p_mode;
    assign {p_mode, p_dir, p_load, p_stop, p_start} = press;

    state_t        state_reg, state_next;
    logic [TW-1:0] presc_reg, presc_next;
    logic [SW-1:0] scan_reg, scan_next;
    logic [1:0]    mod_next;
    logic [7:0]    wrap_next;
    logic          cout_reg, cout_prev_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (p_load) state_next = ST_LOAD;
                      else if (p_start) state_next = ST_RUN;
            ST_LOAD:  state_next = ST_PAUSE;
            ST_RUN:   if (p_load) state_next = ST_LOAD;
                      else if (p_stop) state_next = ST_PAUSE;
            ST_PAUSE: if (p_load) state_next = ST_LOAD;
                      else if (p_stop) state_next = ST_IDLE;
                      else if (p_start) state_next = ST_RUN;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        presc_next = presc_reg;
        if (state_reg == ST_IDLE && state_next == ST_RUN)
            presc_next = '0;
        else if (state_reg == ST_RUN)
            presc_next = (presc_reg == TW'(TICK_DIV - 1)) ? '0 : presc_reg + TW'(1);

        scan_next = (scan_reg == SW'(SCAN_DIV - 1)) ? '0 : scan_reg + SW'(1);

        mod_next = mod_sel;
        if (p_mode && (state_reg == ST_IDLE || state_reg == ST_PAUSE))
            mod_next = (mod_sel == 2'd2) ? 2'd0 : mod_sel + 2'd1;

        wrap_next = wrap_count;
        if (state_reg == ST_PAUSE && state_next == ST_IDLE)
            wrap_next = 8'd0;
        else if (state_reg == ST_RUN && cout_reg && !cout_prev_reg && wrap_count != 8'hFF)
            wrap_next = wrap_count + 8'd1;
    end

    // Outputs are registered from next-state values so they align with the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            presc_reg     <= '0;
            scan_reg      <= '0;
            cout_reg      <= 1'b0;
            cout_prev_reg <= 1'b0;
            enable        <= 1'b0;
            load          <= 1'b0;
            dir_sel       <= 1'b1;
            mod_sel       <= 2'd0;
            data          <= 4'd0;
            count_tick    <= 1'b0;
            scan_tick     <= 1'b0;
            wrap_count    <= 8'd0;
        end else begin
            state_reg     <= state_next;
            presc_reg     <= presc_next;
            scan_reg      <= scan_next;
            cout_reg      <= cout;
            cout_prev_reg <= cout_reg;
            enable        <= (state_next == ST_RUN) || (state_next == ST_LOAD);
            load          <= (state_next == ST_LOAD);
            if (state_next == ST_LOAD && state_reg != ST_LOAD)
                data <= data_sw;
            if (p_dir)
                dir_sel <= ~dir_sel;
            mod_sel       <= mod_next;
            count_tick    <= (state_next == ST_RUN) && (presc_next == TW'(TICK_DIV - 1));
            scan_tick     <= (scan_next == SW'(SCAN_DIV - 1));
            wrap_count    <= wrap_next;
        end
    end

    assign state = state_reg;

endmodule

// File: tb/tb_counter_run_controller.sv
// Scoreboard bench for counter_run_controller: stimulus queues expected events with their
// cycle stamps; a negedge monitor pops and compares whenever the DUT shows an event.
module tb_counter_run_controller;
    localparam int TD = 10;
    localparam int SD = 4;
    localparam int DD = 4;
    localparam logic [1:0] IDLE = 2'd0, LOADS = 2'd1, RUN = 2'd2, PAUSE = 2'd3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] btns = 5'd0;
    logic [3:0] data_sw = 4'd0;
    logic       cout = 1'b0;
    logic       enable, load, dir_sel, count_tick, scan_tick;
    logic [1:0] mod_sel, state;
    logic [3:0] data;
    logic [7:0] wrap_count;

    counter_run_controller #(.TICK_DIV(TD), .SCAN_DIV(SD), .DEB_CYCLES(DD)) dut (
        .clock(clock), .reset(reset),
        .btn_start(btns[0]), .btn_stop(btns[1]), .btn_load(btns[2]),
        .btn_dir(btns[3]), .btn_mode(btns[4]),
        .data_sw(data_sw), .cout(cout),
        .enable(enable), .load(load), .dir_sel(dir_sel), .mod_sel(mod_sel),
        .data(data), .count_tick(count_tick), .scan_tick(scan_tick),
        .state(state), .wrap_count(wrap_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       en;
        logic       ld;
        logic [3:0] dat;
        logic       dir;
        logic [1:0] mod;
    } sev_t;
    typedef struct {
        int         cyc;
        logic [7:0] val;
    } wev_t;

    sev_t sq[$];
    int   tq[$];
    wev_t wq[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;
    int rl_cyc = 0;

    // Hand-tracked expected front-panel state.
    logic [1:0] m_st = IDLE, m_mod = 2'd0;
    logic       m_en = 1'b0, m_ld = 1'b0, m_dir = 1'b1;
    logic [3:0] m_dat = 4'd0;

    int rel_at[5];

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            for (int i = 0; i < 5; i++)
                if (btns[i] && cyc >= rel_at[i]) btns[i] = 1'b0;
        end
    endtask

    task automatic press(input int idx, input int len);
        rel_at[idx] = cyc + len;
        btns[idx] = 1'b1;
    endtask

    task automatic exp_state(input int c);
        sev_t e;
        e.cyc = c; e.st = m_st; e.en = m_en; e.ld = m_ld;
        e.dat = m_dat; e.dir = m_dir; e.mod = m_mod;
        sq.push_back(e);
    endtask

    task automatic exp_wrap(input int c, input int v);
        wev_t e;
        e.cyc = c; e.val = 8'(v);
        wq.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor
    logic [1:0] p_st, p_mod;
    logic       p_en, p_dir;
    logic [3:0] p_dat;
    logic [7:0] p_wrap;
    sev_t       se;
    wev_t       we;
    int         tc;

    always @(negedge clock) begin
        if (mon_on) begin
            n_cmp++;
            if (scan_tick != (((cyc - rl_cyc) % SD) == SD - 1)) begin
                n_bad++;
                $display("FAIL scan_tick @cyc %0d: got %0b", cyc, scan_tick);
            end
            if (state != p_st || enable != p_en || data != p_dat || dir_sel != p_dir ||
                mod_sel != p_mod || load) begin
                n_cmp++;
                if (sq.size() == 0) begin
                    n_bad++;
                    $display("FAIL state_evt: unexpected at cyc %0d st=%0d en=%0b ld=%0b data=%h dir=%0b mod=%0d",
                             cyc, state, enable, load, data, dir_sel, mod_sel);
                end else begin
                    se = sq.pop_front();
                    if (se.cyc != cyc || se.st != state || se.en != enable || se.ld != load ||
                        se.dat != data || se.dir != dir_sel || se.mod != mod_sel) begin
                        n_bad++;
                        $display("FAIL state_evt: got cyc=%0d st=%0d en=%0b ld=%0b data=%h dir=%0b mod=%0d, expected cyc=%0d st=%0d en=%0b ld=%0b data=%h dir=%0b mod=%0d",
                                 cyc, state, enable, load, data, dir_sel, mod_sel,
                                 se.cyc, se.st, se.en, se.ld, se.dat, se.dir, se.mod);
                    end else begin
                        $display("state  cyc=%0d st=%0d en=%0b ld=%0b data=%h dir=%0b mod=%0d ok",
                                 cyc, state, enable, load, data, dir_sel, mod_sel);
                    end
                end
            end
            if (count_tick) begin
                n_cmp++;
                if (tq.size() == 0) begin
                    n_bad++;
                    $display("FAIL count_tick: unexpected at cyc %0d", cyc);
                end else begin
                    tc = tq.pop_front();
                    if (tc != cyc) begin
                        n_bad++;
                        $display("FAIL count_tick: got cyc %0d, expected cyc %0d", cyc, tc);
                    end else begin
                        $display("tick   cyc=%0d ok", cyc);
                    end
                end
            end
            if (wrap_count != p_wrap) begin
                n_cmp++;
                if (wq.size() == 0) begin
                    n_bad++;
                    $display("FAIL wrap_count: unexpected change to %0d at cyc %0d", wrap_count, cyc);
                end else begin
                    we = wq.pop_front();
                    if (we.cyc != cyc || we.val != wrap_count) begin
                        n_bad++;
                        $display("FAIL wrap_count: got %0d at cyc %0d, expected %0d at cyc %0d",
                                 wrap_count, cyc, we.val, we.cyc);
                    end else begin
                        $display("wrap   cyc=%0d val=%0d ok", cyc, wrap_count);
                    end
                end
            end
        end
        p_st = state; p_en = enable; p_dat = data; p_dir = dir_sel;
        p_mod = mod_sel; p_wrap = wrap_count;
    end

    int t, r, s, tm, w, c0, tl, ts;

    initial begin
        // Reset values must appear without any clock edge.
        #1 reset = 1'b1;
        #2;
        chk("rst_state", int'(state), 0);
        chk("rst_enable", int'(enable), 0);
        chk("rst_load", int'(load), 0);
        chk("rst_dir_sel", int'(dir_sel), 1);
        chk("rst_mod_sel", int'(mod_sel), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_count_tick", int'(count_tick), 0);
        chk("rst_scan_tick", int'(scan_tick), 0);
        chk("rst_wrap_count", int'(wrap_count), 0);
        step(3);
        reset = 1'b0;
        rl_cyc = cyc;
        mon_on = 1'b1;
        step(12);

        // Short glitch: no press expected.
        press(0, 3);
        step(12);

        // Start press: RUN 8 clocks after first sampled edge, ticks at RUN clocks 10 and 20.
        t = cyc;
        r = t + 9;
        m_st = RUN; m_en = 1'b1; exp_state(r);
        tq.push_back(r + 9);
        tq.push_back(r + 19);
        press(0, 20);
        step(25);
        press(1, 8);
        m_st = PAUSE; m_en = 1'b0; exp_state(r + 25);
        step(14);

        // Resume: prescaler held at 5, next tick on 5th RUN clock.
        s = cyc + 9;
        m_st = RUN; m_en = 1'b1; exp_state(s);
        tq.push_back(s + 4);
        tq.push_back(s + 14);
        press(0, 8);
        step(10);
        press(4, 8);          // mode while in RUN: ignored
        step(6);
        data_sw = 4'h5;
        m_st = LOADS; m_en = 1'b1; m_ld = 1'b1; m_dat = 4'h5; exp_state(s + 16);
        m_st = PAUSE; m_en = 1'b0; m_ld = 1'b0; exp_state(s + 17);
        press(2, 8);          // load and stop together: load wins
        press(1, 8);
        step(13);

        // Mode stepping in PAUSE: 1, 2, 0.
        tm = cyc;
        for (int k = 0; k < 3; k++) begin
            m_mod = (m_mod == 2'd2) ? 2'd0 : m_mod + 2'd1;
            exp_state(tm + 14 * k + 9);
        end
        for (int k = 0; k < 3; k++) begin
            press(4, 6);
            step(14);
        end

        // Wrap counting in RUN with saturation.
        w = cyc + 9;
        m_st = RUN; m_en = 1'b1; exp_state(w);
        press(0, 8);
        step(11);
        c0 = cyc;
        for (int k = 0; k <= 60; k++) tq.push_back(w + 8 + 10 * k);
        for (int i = 0; i < 255; i++) exp_wrap(c0 + 2 * i + 2, i + 1);
        for (int i = 0; i < 300; i++) begin
            cout = 1'b1;
            step(1);
            cout = 1'b0;
            step(1);
        end
        step(2);
        m_st = PAUSE; m_en = 1'b0; exp_state(c0 + 611);
        press(1, 8);
        step(13);
        cout = 1'b1;          // cout edge in PAUSE: no count
        step(1);
        cout = 1'b0;
        step(4);
        m_st = IDLE; exp_state(c0 + 629);
        exp_wrap(c0 + 629, 0);
        press(1, 8);
        step(20);

        // Load from IDLE with dir toggled during the LOAD cycle.
        data_sw = 4'hA;
        tl = cyc;
        m_st = LOADS; m_en = 1'b1; m_ld = 1'b1; m_dat = 4'hA; exp_state(tl + 9);
        m_st = PAUSE; m_en = 1'b0; m_ld = 1'b0; m_dir = 1'b0; exp_state(tl + 10);
        press(2, 8);
        step(1);
        press(3, 8);
        step(20);

        // stop: PAUSE -> IDLE, then stop in IDLE ignored, then mode in IDLE accepted.
        ts = cyc;
        m_st = IDLE; exp_state(ts + 9);
        press(1, 8);
        step(20);
        press(1, 8);
        step(20);
        ts = cyc;
        m_mod = 2'd1; exp_state(ts + 9);
        press(4, 6);
        step(20);

        mon_on = 1'b0;
        while (sq.size() > 0) begin
            se = sq.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL state_evt: never seen, expected cyc=%0d st=%0d", se.cyc, se.st);
        end
        while (tq.size() > 0) begin
            tc = tq.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL count_tick: never seen, expected cyc=%0d", tc);
        end
        while (wq.size() > 0) begin
            we = wq.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL wrap_count: never seen, expected %0d at cyc=%0d", we.val, we.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_run_controller.md
# counter_run_controller

Front-panel sequencer for the multi-function 4-bit counter. It debounces five push-buttons and runs a four-state run/pause/load FSM. It drives the counter's `enable`, `load`, `dir_sel`, `mod_sel` and `data` inputs, generates the count and display-scan strobes, and tallies counter wrap-arounds reported on `cout`. It sits between board I/O and the counter/display datapath.

## Interface
- `TICK_DIV`, 50000: count-strobe period in clocks (≥2)
- `SCAN_DIV`, 500: display-scan strobe period in clocks (≥2)
- `DEB_CYCLES`, 1000: stable cycles required to accept a button level change (≥1)

- `clock`  in  1  system clock, all logic rising-edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `btn_start`, `btn_stop`, `btn_load`, `btn_dir`, `btn_mode`  in  1 each  raw, asynchronous push-buttons, active-high
- `data_sw`  in  4  preset value switches
- `cout`  in  1  carry/borrow flag from the counter
- `enable`  out  1  counter enable
- `load`  out  1  counter load strobe
- `dir_sel`  out  1  1 = up, 0 = down
- `mod_sel`  out  2  0 = mod-8, 1 = mod-10, 2 = mod-16; never 3
- `data`  out  4  preset value presented to the counter
- `count_tick`  out  1  one-cycle strobe every `TICK_DIV` clocks while counting
- `scan_tick`  out  1  one-cycle strobe every `SCAN_DIV` clocks, free-running
- `state`  out  2  FSM state code
- `wrap_count`  out  8  saturating count of `cout` rising edges in RUN

## Operation
- **Buttons**
  - Each button passes through a 2-flop synchronizer, then a debounce counter.
  - The debounced level flips only after the synchronized level has differed from it for `DEB_CYCLES` consecutive clocks. Any agreeing sample clears the counter.
  - A 0→1 flip of the debounced level produces a one-cycle press pulse. Releases produce nothing.
- **FSM states:** IDLE = 0, LOAD = 1, RUN = 2, PAUSE = 3.
  - IDLE: `enable=0`. load → LOAD. start → RUN. stop is ignored.
  - LOAD: `enable=1`, `load=1`. Lasts exactly one cycle, then → PAUSE unconditionally. Presses in this cycle are dropped.
  - RUN: `enable=1`. load → LOAD. stop → PAUSE.
  - PAUSE: `enable=0`. load → LOAD. start → RUN. stop → IDLE and clears `wrap_count` to 0.
- **Priority for simultaneous pulses:** load > stop > start.
- **`data`:** captures `data_sw` on the clock that enters LOAD and is held until the next LOAD.
- **`btn_dir`:** toggles `dir_sel` in any state, including LOAD.
- **`btn_mode`:** steps `mod_sel` 0→1→2→0. Accepted only in IDLE or PAUSE; ignored in RUN and LOAD.
- **Independence:** dir and mode pulses are independent of, and concurrent with, FSM transitions.
- **Prescaler:** counts 0..`TICK_DIV`-1.
  - Increments only in RUN and holds its value in PAUSE and LOAD.
  - Cleared to 0 on the IDLE→RUN transition.
  - `count_tick` is 1 in the cycle the prescaler equals `TICK_DIV`-1 while in RUN. The prescaler then wraps to 0.
- **`scan_tick`:** free-running 0..`SCAN_DIV`-1 counter, strobe at terminal value. It is unaffected by the FSM.
- **`wrap_count`:**
  - `cout` is registered once.
  - A 0→1 transition while `state` = RUN increments `wrap_count`, saturating at 255.

## Timing
- All outputs are registered. A press pulse in cycle t changes `state`/`enable`/`load`/`dir_sel`/`mod_sel` at t+1.
- Latency from the first rising edge sampling a stable raw high to the press pulse is exactly `DEB_CYCLES`+3 clocks. The FSM response follows 1 clock later.
- A raw glitch shorter than `DEB_CYCLES` synchronized cycles produces no pulse.
- `load` is high for exactly one clock per LOAD entry. `data` is valid in that same cycle and stays stable afterward.
- **Reset values** (immediate on reset assertion, no clock needed):
  - `state`=IDLE, `enable`=0, `load`=0, `dir_sel`=1, `mod_sel`=0, `data`=0
  - `count_tick`=0, `scan_tick`=0, `wrap_count`=0
  - all synchronizers, debounce counters, prescalers = 0
- Reset mid-LOAD or mid-RUN aborts with no further strobe.
- First `scan_tick` after reset release occurs at clock `SCAN_DIV`.
- First `count_tick` occurs `TICK_DIV` clocks after entering RUN from IDLE. After PAUSE→RUN it resumes from the held prescaler value.

## Test plan
All scenarios use `TICK_DIV`=10, `SCAN_DIV`=4, `DEB_CYCLES`=4.

- **Reset/strobes:** reset, release, no buttons → all outputs at reset values. `scan_tick` pulses every 4th clock; `count_tick` stays 0.
- **Debounce:** 3-clock `btn_start` glitch → no transition. 20-clock press → `state` becomes RUN exactly 8 clocks after the first sampled-high edge, `enable`=1.
- **Load:** IDLE, `data_sw`=4'hA, press load → one-cycle `load`=1 with `data`=A, then `state`=PAUSE, `enable`=0.
- **Priority:** in RUN, press load and stop in the same cycle → LOAD, then PAUSE. Press mode while in RUN → `mod_sel` unchanged. Press mode in PAUSE three times → 1, 2, 0.
- **Count strobe:** in RUN for 25 clocks → `count_tick` at clocks 10 and 20. Pause at 25, resume → next tick 5 clocks after re-entry.
- **Wrap counting:** in RUN, toggle `cout` 0→1 300 times → `wrap_count`=255. Pulse `cout` while in PAUSE → no change. stop from PAUSE → IDLE, `wrap_count`=0.
